music_sequencer: RTL and testbench

//  Score sequencer for the PWM tone generator. Steps one score entry per crotchet, issues each

---
 rtl/music_pkg.sv | 27 ++
 rtl/music_if.sv | 15 +
 rtl/beat_timer.sv | 42 ++++
 rtl/music_sequencer.sv | 132 +++++++++++++
 tb/tb_music_sequencer.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/music_pkg.sv
// music_pkg
//   Shared definitions for the music sequencer: FSM state encoding, score
//   entry field positions and the note code width.
//   No ports.
package music_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_PLAY
  } state_t;

  localparam int NOTE_W     = 6;
  localparam int NOTE_MSB   = 5;
  localparam int TIE_BIT    = 6;
  localparam int SCORE_W    = 8;
  localparam int CROTCHET_W = 7;

  localparam logic [NOTE_W-1:0] NOTE_REST = 6'd0;

  function automatic logic is_rest(input logic [SCORE_W-1:0] entry);
    return entry[NOTE_MSB:0] == NOTE_REST;
  endfunction

endpackage

// File: rtl/music_if.sv
// music_if
//   Note handshake between the sequencer and the PWM tone generator.
//   note_code  : note offered to the tone generator
//   note_valid : offer strobe, held until accepted or abandoned
//   note_ready : tone generator accepts; transfer on valid & ready
interface music_if;

  logic [music_pkg::NOTE_W-1:0] note_code;
  logic                         note_valid;
  logic                         note_ready;

  modport master (output note_code, output note_valid, input note_ready);
  modport slave  (input note_code, input note_valid, output note_ready);

endinterface

// File: rtl/beat_timer.sv
// beat_timer
//   Crotchet tick counter. Counts 0..CROTCHET_TICKS-1 while enabled and is
//   held at zero while disabled or cleared.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_en           : count enable (sequencer not idle)
//   i_clr          : synchronous clear
//   o_boundary     : last tick of the crotchet
//   o_gap_next     : the next tick lies in the trailing articulation gap
module beat_timer #(
  parameter int CROTCHET_TICKS = 25_000_000,
  parameter int GAP_TICKS      = 2_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_boundary,
  output logic o_gap_next
);

  localparam int TICK_W = $clog2(CROTCHET_TICKS);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(CROTCHET_TICKS - 1);
  // Compare one tick early so the registered gate is already low on the
  // first gap tick, giving exactly GAP_TICKS silent cycles.
  localparam logic [TICK_W-1:0] GAP_PRE   = TICK_W'(CROTCHET_TICKS - GAP_TICKS - 1);

  logic [TICK_W-1:0] r_tick;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr || !i_en) begin
      r_tick <= '0;
    end else if (o_boundary) begin
      r_tick <= '0;
    end else begin
      r_tick <= r_tick + 1'b1;
    end
  end

  assign o_boundary = i_en && (r_tick == LAST_TICK);
  assign o_gap_next = i_en && (r_tick >= GAP_PRE);

endmodule

// File: rtl/music_sequencer.sv
// music_sequencer
//   Steps one score entry per crotchet, offers each note to the tone
//   generator over valid/ready and gates articulation gaps.
//   i_clk, i_rst_n    : clock, synchronous active-low reset
//   i_run             : 1 = play, 0 = stop and hold position
//   o_score_addr      : score ROM address (= crotchet)
//   i_score_data      : registered ROM data, [5:0] note, [6] tie, [7] reserved
//   note_if (master)  : note_code / note_valid / note_ready
//   o_note_gate       : tone audible
//   o_crotchet        : current score index
//   o_crotchet_pulse  : one-cycle strobe when o_crotchet takes a new value
//
// state  | meaning
// IDLE   | stopped, tick held at 0
// FETCH  | ROM address settling, data arrives next cycle
// DECODE | latch tie, start note offer or silence a rest
// ISSUE  | note offered, waiting for note_ready
// PLAY   | waiting for the crotchet boundary
module music_sequencer
  import music_pkg::*;
#(
  parameter int CROTCHET_TICKS = 25_000_000,
  parameter int GAP_TICKS      = 2_000_000,
  parameter int SCORE_LEN      = 112
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_run,
  output logic [CROTCHET_W-1:0] o_score_addr,
  input  logic [SCORE_W-1:0]    i_score_data,
  music_if.master               note_if,
  output logic                  o_note_gate,
  output logic [CROTCHET_W-1:0] o_crotchet,
  output logic                  o_crotchet_pulse
);

  localparam logic [CROTCHET_W-1:0] LAST_IDX = CROTCHET_W'(SCORE_LEN - 1);

  state_t                r_state;
  logic [CROTCHET_W-1:0] r_crotchet;
  logic [NOTE_W-1:0]     r_note_code;
  logic                  r_note_valid;
  logic                  r_note_gate;
  logic                  r_pulse;
  logic                  r_tie;

  logic w_boundary;
  logic w_gap_next;
  logic w_gap_drop;
  logic w_unused_reserved;

  assign w_unused_reserved = i_score_data[SCORE_W-1];
  assign w_gap_drop        = w_gap_next && !r_tie;

  beat_timer #(
    .CROTCHET_TICKS (CROTCHET_TICKS),
    .GAP_TICKS      (GAP_TICKS)
  ) u_beat_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (r_state != ST_IDLE),
    .i_clr      (!i_run),
    .o_boundary (w_boundary),
    .o_gap_next (w_gap_next)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_crotchet   <= '0;
      r_note_code  <= '0;
      r_note_valid <= 1'b0;
      r_note_gate  <= 1'b0;
      r_pulse      <= 1'b0;
      r_tie        <= 1'b0;
    end else if (!i_run) begin
      r_state      <= ST_IDLE;
      r_note_valid <= 1'b0;
      r_note_gate  <= 1'b0;
      r_pulse      <= 1'b0;
    end else if (w_boundary) begin
      // Boundary beats everything, including a handshake in the same cycle.
      r_crotchet   <= (r_crotchet == LAST_IDX) ? '0 : r_crotchet + 1'b1;
      r_pulse      <= 1'b1;
      r_state      <= ST_FETCH;
      r_note_valid <= 1'b0;
      if (r_state == ST_ISSUE) begin
        r_note_gate <= 1'b0;
      end
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        ST_IDLE:   r_state <= ST_FETCH;
        ST_FETCH:  r_state <= ST_DECODE;
        ST_DECODE: begin
          r_tie <= i_score_data[TIE_BIT];
          if (is_rest(i_score_data)) begin
            r_note_gate <= 1'b0;
            r_state     <= ST_PLAY;
          end else begin
            r_note_code  <= i_score_data[NOTE_MSB:0];
            r_note_valid <= 1'b1;
            r_state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (note_if.note_ready) begin
            r_note_valid <= 1'b0;
            r_note_gate  <= !w_gap_drop;
            r_state      <= ST_PLAY;
          end else if (w_gap_drop) begin
            r_note_gate <= 1'b0;
          end
        end
        ST_PLAY: begin
          if (w_gap_drop) begin
            r_note_gate <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_score_addr       = r_crotchet;
  assign o_crotchet         = r_crotchet;
  assign o_crotchet_pulse   = r_pulse;
  assign o_note_gate        = r_note_gate;
  assign note_if.note_code  = r_note_code;
  assign note_if.note_valid = r_note_valid;

endmodule

// File: tb/tb_music_sequencer.sv
// tb_music_sequencer
//   Directed bench for music_sequencer with CROTCHET_TICKS=16, GAP_TICKS=4,
//   SCORE_LEN=4 and a 1-cycle-latency score ROM model.
module tb_music_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [6:0] score_addr;
  logic [7:0] score_data;
  logic       note_gate;
  logic [6:0] crotchet;
  logic       crotchet_pulse;
  logic [7:0] rom [4];

  int n_checks = 0;
  int n_fail   = 0;

  music_if nif ();

  music_sequencer #(
    .CROTCHET_TICKS (16),
    .GAP_TICKS      (4),
    .SCORE_LEN      (4)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_run            (run),
    .o_score_addr     (score_addr),
    .i_score_data     (score_data),
    .note_if          (nif),
    .o_note_gate      (note_gate),
    .o_crotchet       (crotchet),
    .o_crotchet_pulse (crotchet_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) score_data <= rom[score_addr[1:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after an edge with reset released and
  // run=1, so the next edge moves IDLE -> FETCH (sample index k=0).
  task automatic start_run(input logic ready);
    rst_n = 1'b0;
    run   = 1'b0;
    nif.note_ready = ready;
    cyc(2);
    rst_n = 1'b1;
    run   = 1'b1;
  endtask

  initial begin
    int t;
    int c;
    logic note;
    logic [5:0] codes [4];

    // ---------------- reset and basic play, ready tied high ----------------
    rom[0] = 8'h05; rom[1] = 8'h07; rom[2] = 8'h00; rom[3] = 8'h09;
    codes[0] = 6'd5; codes[1] = 6'd7; codes[2] = 6'd0; codes[3] = 6'd9;
    rst_n = 1'b0;
    run   = 1'b0;
    nif.note_ready = 1'b1;
    cyc(3);
    chk("rst_valid", 32'(nif.note_valid), 0);
    chk("rst_gate",  32'(note_gate), 0);
    chk("rst_pulse", 32'(crotchet_pulse), 0);
    chk("rst_crot",  32'(crotchet), 0);
    chk("rst_code",  32'(nif.note_code), 0);

    start_run(1'b1);
    for (int k = 0; k < 65; k++) begin
      cyc(1);
      t = k % 16;
      c = (k / 16) % 4;
      note = (c != 2);
      chk("play_valid", 32'(nif.note_valid), 32'(note && t == 2));
      if (note && t == 2) chk("play_code", 32'(nif.note_code), 32'(codes[c]));
      chk("play_gate",  32'(note_gate), 32'(note && t >= 3 && t <= 11));
      chk("play_pulse", 32'(crotchet_pulse), 32'(t == 0 && k >= 16));
      chk("play_crot",  32'(crotchet), 32'(c));
      chk("play_addr",  32'(score_addr), 32'(c));
    end

    // ---------------- ready withheld for 20 cycles ----------------
    start_run(1'b0);
    for (int k = 0; k < 32; k++) begin
      cyc(1);
      if (k < 16) begin
        chk("hold_valid", 32'(nif.note_valid), 32'(k >= 2));
        if (k >= 2) chk("hold_code", 32'(nif.note_code), 5);
        chk("hold_gate", 32'(note_gate), 0);
      end else begin
        chk("hold_valid1", 32'(nif.note_valid), 32'(k == 18 || k == 19));
        chk("hold_gate1",  32'(note_gate), 32'(k >= 20 && k <= 27));
      end
      chk("hold_pulse", 32'(crotchet_pulse), 32'(k == 16));
      chk("hold_crot",  32'(crotchet), 32'(k >= 16));
      if (k == 19) nif.note_ready = 1'b1;
    end

    // ---------------- tied entry 1 ----------------
    rom[1] = 8'h47; rom[2] = 8'h07;
    start_run(1'b1);
    for (int k = 0; k < 48; k++) begin
      cyc(1);
      t = k % 16;
      c = k / 16;
      chk("tie_valid", 32'(nif.note_valid), 32'(t == 2));
      if (t == 2) chk("tie_code", 32'(nif.note_code), 32'((c == 0) ? 5 : 7));
      if (c == 0)      chk("tie_gate0", 32'(note_gate), 32'(t >= 3 && t <= 11));
      else if (c == 1) chk("tie_gate1", 32'(note_gate), 32'(t >= 3));
      else             chk("tie_gate2", 32'(note_gate), 32'(t <= 11));
    end

    // ---------------- run=0 mid-PLAY at crotchet 1 ----------------
    rom[1] = 8'h07; rom[2] = 8'h00;
    start_run(1'b1);
    cyc(22);
    chk("stop_pre_gate", 32'(note_gate), 1);
    chk("stop_pre_crot", 32'(crotchet), 1);
    run = 1'b0;
    cyc(1);
    chk("stop_gate",  32'(note_gate), 0);
    chk("stop_valid", 32'(nif.note_valid), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("stop_pulse", 32'(crotchet_pulse), 0);
      chk("stop_crot",  32'(crotchet), 1);
      chk("stop_gate",  32'(note_gate), 0);
    end
    run = 1'b1;
    for (int j = 0; j < 17; j++) begin
      cyc(1);
      chk("resume_pulse", 32'(crotchet_pulse), 32'(j == 16));
      chk("resume_valid", 32'(nif.note_valid), 32'(j == 2));
      if (j == 2) begin
        chk("resume_addr", 32'(score_addr), 1);
        chk("resume_code", 32'(nif.note_code), 7);
      end
    end
    chk("resume_crot", 32'(crotchet), 2);

    // ---------------- reset during ISSUE with ready=1 ----------------
    start_run(1'b1);
    cyc(19);
    chk("rstiss_pre_valid", 32'(nif.note_valid), 1);
    chk("rstiss_pre_crot",  32'(crotchet), 1);
    rst_n = 1'b0;
    cyc(1);
    chk("rstiss_valid", 32'(nif.note_valid), 0);
    chk("rstiss_gate",  32'(note_gate), 0);
    chk("rstiss_pulse", 32'(crotchet_pulse), 0);
    chk("rstiss_crot",  32'(crotchet), 0);
    chk("rstiss_code",  32'(nif.note_code), 0);
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      cyc(1);
      chk("rstiss_idle_valid", 32'(nif.note_valid), 32'(j == 2));
    end
    chk("rstiss_addr", 32'(score_addr), 0);
    chk("rstiss_code5", 32'(nif.note_code), 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
